serial_io_sequencer: RTL and testbench
======================================

Name: serial_io_sequencer

Overview:
- Command sequencer between the CPU control unit and the serial RX/TX FIFOs.
- Turns a 3-bit serial command plus a start pulse into FIFO pop/push strobes, byte capture, and a single-cycle drive of the shared 16-bit tri-state bus.
- Reports completion, busy and timeout so the control unit can stall on empty/full FIFOs instead of reading stale data.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles to wait in WAIT_RX/WAIT_TX before aborting; 0 = wait forever.
- TO_WIDTH, 11, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- bus  inout  16  shared data bus; driven only in DRIVE state, else 16'bZ.
- cmd  input  3  000 nop, 001 write, 010 read, 011 status (optional), 1xx illegal.
- start  input  1  command strobe, sampled in IDLE only.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- timeout  output  1  one-cycle pulse, coincident with done on abort.
- SerialData_in  input  8  RX FIFO head; valid the cycle after SerialRead.
- SerialEmpty  input  1  RX FIFO empty.
- SerialRead  output  1  RX pop strobe.
- SerialData_out  output  8  TX byte, stable whenever SerialWrite is high.
- SerialFull  input  1  TX FIFO full.
- SerialWrite  output  1  TX push strobe.

Behaviour:
- Reset, asynchronous on reset_n low:
  - state = IDLE.
  - busy, done, timeout, SerialRead, SerialWrite = 0.
  - rx_reg, tx_reg, SerialData_out = 0; timeout counter = 0; bus = Z.
- Reset asserted mid-operation aborts immediately: no further strobes, and no done pulse after release.
- States: IDLE, WAIT_RX, RX_POP, RX_LATCH, DRIVE, WAIT_TX, TX_PUSH, ERR.
  - All outputs are registered decodes of state.
  - Cycle k = k-th cycle after the edge that sampled start.
- IDLE, start=1:
  - cmd=010 -> WAIT_RX.
  - cmd=001 -> tx_reg <= bus[7:0] on the same edge, then WAIT_TX.
  - cmd=000 or 1xx -> ERR.
  - start=0 -> stay IDLE.
  - start while busy: ignored, not queued.
- WAIT_RX: SerialEmpty=0 -> RX_POP; otherwise count.
- RX_POP: SerialRead=1 for exactly one cycle -> RX_LATCH.
- RX_LATCH: rx_reg <= SerialData_in -> DRIVE.
- DRIVE: bus = {8'h00, rx_reg}; done=1 for one cycle -> IDLE.
- Read latency with non-empty FIFO: SerialRead in cycle 2, bus driven and done in cycle 4.
- WAIT_TX: SerialFull=0 -> TX_PUSH; otherwise count.
- TX_PUSH: SerialWrite=1 and done=1 for one cycle -> IDLE.
  - SerialData_out = tx_reg, held until the next write command.
  - Write latency with non-full FIFO: push and done in cycle 2.
- ERR: done=1 for one cycle, no FIFO strobe, bus not driven -> IDLE.
- Timeout:
  - Counter clears on entry to WAIT_RX/WAIT_TX and increments each waiting cycle.
  - Reaching TIMEOUT_CYCLES-1 while still empty/full -> done=1, timeout=1, no strobe, bus not driven -> IDLE.
  - FIFO becoming ready on the same cycle as expiry: ready wins, operation proceeds.
  - TIMEOUT_CYCLES=0: counter disabled, never times out.
- At most one strobe per command.
- SerialRead and SerialWrite are never high together.
- Bus is never driven outside DRIVE.

Optional Feature:
- SERIAL_STATUS_EN defined:
  - cmd=011 in IDLE -> DRIVE with bus = {14'b0, SerialFull, SerialEmpty}, sampled at the start edge.
  - done in cycle 1; no FIFO strobe.
- Undefined: cmd=011 behaves exactly as illegal (ERR path, done in cycle 1, bus Z).

Test Plan:
- Reset asserted mid-WAIT_TX -> all outputs 0, bus Z immediately; after release no done/strobe until a new start.
- RX FIFO holds 8'hA5, start with cmd=010 -> SerialRead pulse in cycle 2; bus=16'h00A5 and done=1 in cycle 4 only; bus Z otherwise.
- bus=16'h1234, start with cmd=001, FIFO not full -> SerialWrite pulse in cycle 2 with SerialData_out=8'h34, done same cycle.
- SerialFull held 1, TIMEOUT_CYCLES=8, write command -> no SerialWrite; done and timeout pulse together; busy drops next cycle.
- SerialEmpty=1 for 5 cycles then 0, read command -> single SerialRead, correct byte on bus, timeout=0; second start during busy ignored.
- cmd=111 -> done in cycle 1, no strobes, bus Z. With SERIAL_STATUS_EN, cmd=011 and SerialFull=1, SerialEmpty=0 -> bus=16'h0002 in cycle 1.

Source files
------------

// File: rtl/serial_io_sequencer.sv
// serial_io_sequencer: command sequencer between the CPU control unit and the
// serial RX/TX FIFOs. Turns cmd+start into FIFO pop/push strobes, byte capture
// and a one-cycle drive of the shared 16-bit bus, with busy/done/timeout status.
// Optional status command (cmd=011) is enabled by defining SERIAL_STATUS_EN;
// otherwise cmd=011 takes the illegal-command path.
module serial_io_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_WIDTH       = 11
) (
  input  logic        clock,
  input  logic        reset_n,
  inout  wire  [15:0] bus,
  input  logic [2:0]  cmd,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  input  logic [7:0]  SerialData_in,
  input  logic        SerialEmpty,
  output logic        SerialRead,
  output logic [7:0]  SerialData_out,
  input  logic        SerialFull,
  output logic        SerialWrite
);

  typedef enum logic [2:0] {
    IDLE, WAIT_RX, RX_POP, RX_LATCH, DRIVE, WAIT_TX, TX_PUSH, ERR
  } state_t;

  localparam logic [2:0] CMD_WRITE  = 3'b001;
  localparam logic [2:0] CMD_READ   = 3'b010;
  localparam bit         TO_ENABLED = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST =
    TO_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t              state, next_state;
  logic [TO_WIDTH-1:0] to_cnt;
  logic                cnt_clr, cnt_inc, load_tx, abort, expired;
  logic [7:0]          rx_reg, tx_reg;
  logic                drive_en;
  logic [15:0]         drive_data;
  logic                unused_bus_hi;
`ifdef SERIAL_STATUS_EN
  localparam logic [2:0] CMD_STATUS = 3'b011;
  logic                status_cmd, status_sel;
  logic [1:0]          status_reg;
`endif

  assign expired = TO_ENABLED && (to_cnt == TO_LAST);

  // Next-state decode; FIFO readiness takes priority over timeout expiry.
  always_comb begin
    next_state = state;
    cnt_clr    = '0;
    cnt_inc    = '0;
    load_tx    = '0;
    abort      = '0;
`ifdef SERIAL_STATUS_EN
    status_cmd = '0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          cnt_clr = '1;
          case (cmd)
            CMD_READ:  next_state = WAIT_RX;
            CMD_WRITE: begin
              next_state = WAIT_TX;
              load_tx    = '1;
            end
`ifdef SERIAL_STATUS_EN
            CMD_STATUS: begin
              next_state = DRIVE;
              status_cmd = '1;
            end
`endif
            default:   next_state = ERR;
          endcase
        end
      end
      WAIT_RX: begin
        if (!SerialEmpty) begin
          next_state = RX_POP;
        end else if (expired) begin
          next_state = ERR;
          abort      = '1;
        end else begin
          cnt_inc = TO_ENABLED;
        end
      end
      RX_POP:   next_state = RX_LATCH;
      RX_LATCH: next_state = DRIVE;
      DRIVE:    next_state = IDLE;
      WAIT_TX: begin
        if (!SerialFull) begin
          next_state = TX_PUSH;
        end else if (expired) begin
          next_state = ERR;
          abort      = '1;
        end else begin
          cnt_inc = TO_ENABLED;
        end
      end
      TX_PUSH:  next_state = IDLE;
      ERR:      next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Outputs registered from the next state; a timeout abort passes through ERR
  // so done/timeout pulse while busy is still high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= '0;
      done        <= '0;
      timeout     <= '0;
      SerialRead  <= '0;
      SerialWrite <= '0;
      drive_en    <= '0;
    end else begin
      busy        <= (next_state != IDLE);
      done        <= (next_state == DRIVE) || (next_state == TX_PUSH) ||
                     (next_state == ERR);
      timeout     <= abort;
      SerialRead  <= (next_state == RX_POP);
      SerialWrite <= (next_state == TX_PUSH);
      drive_en    <= (next_state == DRIVE);
    end
  end

  // Timeout counter and data capture registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
      rx_reg <= '0;
      tx_reg <= '0;
    end else begin
      if (cnt_clr)      to_cnt <= '0;
      else if (cnt_inc) to_cnt <= to_cnt + TO_WIDTH'(1);
      if (load_tx)             tx_reg <= bus[7:0];
      if (state == RX_LATCH)   rx_reg <= SerialData_in;
    end
  end

`ifdef SERIAL_STATUS_EN
  // FIFO flags captured on the start edge for the status command.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      status_sel <= '0;
      status_reg <= '0;
    end else if ((state == IDLE) && start) begin
      status_sel <= status_cmd;
      status_reg <= {SerialFull, SerialEmpty};
    end
  end

  assign drive_data = status_sel ? {14'b0, status_reg} : {8'h00, rx_reg};
`else
  assign drive_data = {8'h00, rx_reg};
`endif

  assign bus            = drive_en ? drive_data : 'z;
  assign SerialData_out = tx_reg;
  assign unused_bus_hi  = ^bus[15:8];

endmodule

// File: tb/tb_serial_io_sequencer.sv
// Self-checking bench for serial_io_sequencer: randomized and directed
// commands compared cycle by cycle against a latency/transaction model.
module tb_serial_io_sequencer;

  localparam int TO = 8;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        timeout;
    logic        rd;
    logic        wr;
    logic [7:0]  dout;
    logic [15:0] bus;
  } obs_t;

  typedef struct {
    logic [2:0]  cmd;
    int          k;
    logic [15:0] busv;
    logic [7:0]  rx;
    bit          inject;
  } case_t;

  logic        clock = 1'b0;
  logic        reset_n;
  wire  [15:0] bus;
  logic [15:0] bus_val;
  logic        bus_en;
  logic [2:0]  cmd;
  logic        start;
  logic        busy, done, timeout;
  logic [7:0]  SerialData_in;
  logic        SerialEmpty;
  logic        SerialRead;
  logic [7:0]  SerialData_out;
  logic        SerialFull;
  logic        SerialWrite;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  exp_tx   = 8'h00;

  assign bus = bus_en ? bus_val : 'z;

  always #5 clock = ~clock;

  serial_io_sequencer #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus), .cmd(cmd), .start(start),
    .busy(busy), .done(done), .timeout(timeout),
    .SerialData_in(SerialData_in), .SerialEmpty(SerialEmpty), .SerialRead(SerialRead),
    .SerialData_out(SerialData_out), .SerialFull(SerialFull), .SerialWrite(SerialWrite)
  );

  // Expected outputs in cycle c of a command whose FIFO stays not-ready for k cycles.
  function automatic obs_t model(input logic [2:0] m_cmd, input int k, input logic [1:0] flags0,
                                 input logic [7:0] rx_byte, input logic [7:0] tx_byte,
                                 input int c, output int last);
    obs_t o;
    o = '0;
    o.dout = tx_byte;
    o.bus  = 16'hzzzz;
    last   = 1;
    if (m_cmd == 3'b010 || m_cmd == 3'b001) begin
      if (k < TO) begin
        last = (m_cmd == 3'b010) ? k + 4 : k + 2;
        if (m_cmd == 3'b010) begin
          o.rd = (c == k + 2);
          if (c == last) o.bus = {8'h00, rx_byte};
        end else begin
          o.wr = (c == last);
        end
        o.done = (c == last);
      end else begin
        last      = TO + 1;
        o.done    = (c == last);
        o.timeout = (c == last);
      end
    end
`ifdef SERIAL_STATUS_EN
    else if (m_cmd == 3'b011) begin
      o.done = (c == 1);
      if (c == 1) o.bus = {14'b0, flags0};
    end
`endif
    else begin
      o.done = (c == 1);
    end
    o.busy = (c >= 1) && (c <= last);
    return o;
  endfunction

  function automatic obs_t sample();
    return {busy, done, timeout, SerialRead, SerialWrite, SerialData_out, bus};
  endfunction

  task automatic start_txn(input logic [2:0] t_cmd, input logic [15:0] busv, input logic [1:0] flags0);
    cmd     = t_cmd;
    start   = 1'b1;
    bus_val = busv;
    bus_en  = 1'b1;
    {SerialFull, SerialEmpty} = flags0;
    SerialData_in = 8'($urandom);
    @(posedge clock); #1;
    start  = 1'b0;
    bus_en = 1'b0;
  endtask

  // Inputs for cycle c: the FIFO of interest is not ready for cycles 1..k, and the
  // RX byte is valid only in the cycle after the expected pop.
  task automatic cycle_inputs(input logic [2:0] t_cmd, input int k, input int c,
                              input logic [7:0] rx_byte, input bit inject);
    SerialEmpty   = (t_cmd == 3'b010) ? logic'(c <= k) : 1'($urandom);
    SerialFull    = (t_cmd == 3'b001) ? logic'(c <= k) : 1'($urandom);
    SerialData_in = (t_cmd == 3'b010 && c == k + 3) ? rx_byte : 8'($urandom);
    start         = inject && (c == 2);
    cmd           = 3'($urandom);
  endtask

  task automatic test_reset();
    obs_t exp;
    int   last;
    #2 reset_n = 1'b0;
    #1;
    exp_tx = 8'h00;
    exp = model(3'b000, 0, 2'b00, 8'h00, exp_tx, 0, last);
    n_checks++;
    if (sample() !== exp) begin
      n_fail++;
      $display("FAIL reset_async: got %h, expected %h", sample(), exp);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (sample() !== exp) begin
      n_fail++;
      $display("FAIL reset_held: got %h, expected %h", sample(), exp);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_idle();
    obs_t exp;
    int   last;
    for (int i = 0; i < 6; i++) begin
      start = 1'b0;
      cmd = 3'($urandom);
      {SerialFull, SerialEmpty} = 2'($urandom);
      @(negedge clock);
      exp = model(3'b000, 0, 2'b00, 8'h00, exp_tx, 0, last);
      n_checks++;
      if (sample() !== exp) begin
        n_fail++;
        $display("FAIL idle[%0d]: got %h, expected %h", i, sample(), exp);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_read();
    case_t tc[$];
    obs_t  exp;
    int    last;
    logic [1:0] f0;
    tc.push_back('{3'b010, 0,      16'h0000, 8'hA5, 1'b0});
    tc.push_back('{3'b010, 5,      16'h5A5A, 8'h3C, 1'b1});
    tc.push_back('{3'b010, TO - 1, 16'h0000, 8'h81, 1'b0});
    foreach (tc[i]) begin
      f0 = 2'($urandom);
      exp = model(tc[i].cmd, tc[i].k, f0, tc[i].rx, exp_tx, 0, last);
      start_txn(tc[i].cmd, tc[i].busv, f0);
      for (int c = 1; c <= last + 1; c++) begin
        cycle_inputs(tc[i].cmd, tc[i].k, c, tc[i].rx, tc[i].inject && last >= 2);
        @(negedge clock);
        exp = model(tc[i].cmd, tc[i].k, f0, tc[i].rx, exp_tx, c, last);
        n_checks++;
        if (sample() !== exp) begin
          n_fail++;
          $display("FAIL read[%0d] cycle %0d: got %h, expected %h", i, c, sample(), exp);
        end
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic test_write();
    case_t tc[$];
    obs_t  exp;
    int    last;
    logic [1:0] f0;
    tc.push_back('{3'b001, 0,      16'h1234, 8'h00, 1'b0});
    tc.push_back('{3'b001, 3,      16'hABCD, 8'h00, 1'b1});
    tc.push_back('{3'b001, TO - 1, 16'h00E7, 8'h00, 1'b0});
    foreach (tc[i]) begin
      f0 = 2'($urandom);
      exp_tx = tc[i].busv[7:0];
      exp = model(tc[i].cmd, tc[i].k, f0, tc[i].rx, exp_tx, 0, last);
      start_txn(tc[i].cmd, tc[i].busv, f0);
      for (int c = 1; c <= last + 1; c++) begin
        cycle_inputs(tc[i].cmd, tc[i].k, c, tc[i].rx, tc[i].inject && last >= 2);
        @(negedge clock);
        exp = model(tc[i].cmd, tc[i].k, f0, tc[i].rx, exp_tx, c, last);
        n_checks++;
        if (sample() !== exp) begin
          n_fail++;
          $display("FAIL write[%0d] cycle %0d: got %h, expected %h", i, c, sample(), exp);
        end
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic test_timeout();
    case_t tc[$];
    obs_t  exp;
    int    last;
    logic [1:0] f0;
    tc.push_back('{3'b001, TO + 3, 16'h77C3, 8'h00, 1'b0});
    tc.push_back('{3'b010, TO,     16'h0000, 8'h99, 1'b1});
    foreach (tc[i]) begin
      f0 = 2'($urandom);
      if (tc[i].cmd == 3'b001) exp_tx = tc[i].busv[7:0];
      exp = model(tc[i].cmd, tc[i].k, f0, tc[i].rx, exp_tx, 0, last);
      start_txn(tc[i].cmd, tc[i].busv, f0);
      for (int c = 1; c <= last + 1; c++) begin
        cycle_inputs(tc[i].cmd, tc[i].k, c, tc[i].rx, tc[i].inject && last >= 2);
        @(negedge clock);
        exp = model(tc[i].cmd, tc[i].k, f0, tc[i].rx, exp_tx, c, last);
        n_checks++;
        if (sample() !== exp) begin
          n_fail++;
          $display("FAIL timeout[%0d] cycle %0d: got %h, expected %h", i, c, sample(), exp);
        end
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic test_illegal();
    logic [2:0] cmds [4];
    logic [1:0] f0;
    obs_t exp;
    int   last;
    cmds = '{3'b111, 3'b000, 3'b100, 3'b011};
    foreach (cmds[i]) begin
      f0 = (cmds[i] == 3'b011) ? 2'b10 : 2'($urandom);
      exp = model(cmds[i], 0, f0, 8'h00, exp_tx, 0, last);
      start_txn(cmds[i], 16'($urandom), f0);
      for (int c = 1; c <= last + 1; c++) begin
        cycle_inputs(cmds[i], 0, c, 8'h00, 1'b0);
        @(negedge clock);
        exp = model(cmds[i], 0, f0, 8'h00, exp_tx, c, last);
        n_checks++;
        if (sample() !== exp) begin
          n_fail++;
          $display("FAIL cmd%b cycle %0d: got %h, expected %h", cmds[i], c, sample(), exp);
        end
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic test_random();
    case_t tc;
    obs_t  exp;
    int    last;
    logic [1:0] f0;
    for (int i = 0; i < 40; i++) begin
      tc = '{3'($urandom), int'($urandom_range(0, TO + 2)), 16'($urandom), 8'($urandom),
             1'($urandom)};
      f0 = 2'($urandom);
      if (tc.cmd == 3'b001) exp_tx = tc.busv[7:0];
      exp = model(tc.cmd, tc.k, f0, tc.rx, exp_tx, 0, last);
      start_txn(tc.cmd, tc.busv, f0);
      for (int c = 1; c <= last + 1; c++) begin
        cycle_inputs(tc.cmd, tc.k, c, tc.rx, tc.inject && last >= 2);
        @(negedge clock);
        exp = model(tc.cmd, tc.k, f0, tc.rx, exp_tx, c, last);
        n_checks++;
        if (sample() !== exp) begin
          n_fail++;
          $display("FAIL random[%0d] cmd%b k=%0d cycle %0d: got %h, expected %h",
                   i, tc.cmd, tc.k, c, sample(), exp);
        end
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic test_reset_mid_op();
    obs_t exp;
    int   last;
    exp_tx = 8'hEF;
    start_txn(3'b001, 16'hBEEF, 2'b10);
    for (int c = 1; c <= 3; c++) begin
      SerialFull = 1'b1;
      @(negedge clock);
      exp = model(3'b001, 100, 2'b10, 8'h00, exp_tx, c, last);
      n_checks++;
      if (sample() !== exp) begin
        n_fail++;
        $display("FAIL midop_wait cycle %0d: got %h, expected %h", c, sample(), exp);
      end
      @(posedge clock); #1;
    end
    #2 reset_n = 1'b0;
    #1;
    exp_tx = 8'h00;
    exp = model(3'b000, 0, 2'b00, 8'h00, exp_tx, 0, last);
    n_checks++;
    if (sample() !== exp) begin
      n_fail++;
      $display("FAIL midop_reset: got %h, expected %h", sample(), exp);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      start = 1'b0;
      SerialFull = 1'b0;
      @(negedge clock);
      n_checks++;
      if (sample() !== exp) begin
        n_fail++;
        $display("FAIL midop_release cycle %0d: got %h, expected %h", c, sample(), exp);
      end
    end
    @(posedge clock); #1;
  endtask

  initial begin
    reset_n       = 1'b1;
    start         = 1'b0;
    cmd           = 3'b000;
    bus_en        = 1'b0;
    bus_val       = 16'h0000;
    SerialData_in = 8'h00;
    SerialEmpty   = 1'b1;
    SerialFull    = 1'b0;
    test_reset();
    test_idle();
    test_read();
    test_write();
    test_timeout();
    test_illegal();
    test_random();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
